// File: rtl/opll_reg_writer.sv
// opll_reg_writer
// CPU-side register file for a YM2413-style FM core. The CPU writes an address
// byte (cpu_a0=0) and then a data byte (cpu_a0=1). The data write is parked in
// a one-entry pending buffer. It commits into the channel register array on
// the next stage-3 slot-pipeline enable. The read side presents the
// parameters of channel slot>>1 to the slot pipeline. Those outputs reload
// on every stage-0 enable.
//
// Ports
//   clk, reset        system clock; synchronous active-high reset
//   clkena            slot-pipeline enable, one pulse per stage
//   slot, stage       current slot 0..17 and stage 0..3
//   cpu_wr, cpu_a0,   CPU write strobe, port select (0=address, 1=data),
//   cpu_d             and write data
//   busy, overrun     write pending; one-clk pulse when pending data is replaced
//   fnum, blk, key,   per-slot channel parameters, loaded at stage 0
//   sus, inst, vol
//   rhythm            rhythm-mode bit from register 0x0E bit5 (not per-slot)
//   voice_wr,         one-clk pulse on a commit to 0x00-0x07, with the low
//   voice_addr,       address bits and the data byte
//   voice_data
//
// Build option
//   VM2413_RHYTHM_KEY_EN  When defined, the rhythm key bits from 0x0E bits4:0
//                         are ORed into key for slots 12..17 while rhythm=1.

module opll_reg_writer (
    input  logic       clk,
    input  logic       reset,
    input  logic       clkena,
    input  logic [4:0] slot,
    input  logic [1:0] stage,
    input  logic       cpu_wr,
    input  logic       cpu_a0,
    input  logic [7:0] cpu_d,
    output logic       busy,
    output logic       overrun,
    output logic [8:0] fnum,
    output logic [2:0] blk,
    output logic       key,
    output logic       sus,
    output logic [3:0] inst,
    output logic [3:0] vol,
    output logic       rhythm,
    output logic       voice_wr,
    output logic [2:0] voice_addr,
    output logic [7:0] voice_data
);

    localparam int NUM_CH = 9;

    // CPU-side latches
    logic [7:0] addr_reg;
    logic [7:0] pend_addr;
    logic [7:0] pend_data;

    // Channel register array
    logic [NUM_CH-1:0][8:0] ch_fnum;
    logic [NUM_CH-1:0][2:0] ch_blk;
    logic [NUM_CH-1:0]      ch_key;
    logic [NUM_CH-1:0]      ch_sus;
    logic [NUM_CH-1:0][3:0] ch_inst;
    logic [NUM_CH-1:0][3:0] ch_vol;
    logic                   rhy_en;
`ifdef VM2413_RHYTHM_KEY_EN
    logic [4:0]             rhy_keys;   // {BD, SD, TOM, CYM, HH}
`endif

    // Write-side decode
    logic       data_wr;
    logic       addr_wr;
    logic       commit;
    logic [3:0] pend_ch;
    logic       ch_ok;
    logic       wr_fnum;
    logic       wr_ctl;
    logic       wr_ivol;
    logic       wr_rhy;
    logic       wr_voice;

    // Read-side decode
    logic       load;
    logic       slot_ok;
    logic [3:0] rd_ch;
    logic       key_next;

    always_comb begin
        data_wr  = cpu_wr &  cpu_a0;
        addr_wr  = cpu_wr & ~cpu_a0;
        commit   = clkena && (stage == 2'd3) && busy;
        pend_ch  = pend_addr[3:0];
        ch_ok    = (pend_ch <= 4'd8);
        // Low nibbles 9..F of the 0x1n/0x2n/0x3n rows are not channels and
        // are dropped like any other unmapped address.
        wr_fnum  = commit && (pend_addr[7:4] == 4'h1) && ch_ok;
        wr_ctl   = commit && (pend_addr[7:4] == 4'h2) && ch_ok;
        wr_ivol  = commit && (pend_addr[7:4] == 4'h3) && ch_ok;
        wr_rhy   = commit && (pend_addr == 8'h0E);
        wr_voice = commit && (pend_addr[7:3] == 5'd0);
    end

    // Address latch and one-deep pending buffer. A data write on the commit
    // edge lands behind the entry being committed, so it is not an overrun.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_reg  <= 8'd0;
            pend_addr <= 8'd0;
            pend_data <= 8'd0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (addr_wr)
                addr_reg <= cpu_d;
            if (data_wr) begin
                pend_addr <= addr_reg;
                pend_data <= cpu_d;
                busy      <= 1'b1;
                overrun   <= busy && !commit;
            end else if (commit) begin
                busy <= 1'b0;
            end
        end
    end

    // Commit into the channel register array
    always_ff @(posedge clk) begin
        if (reset) begin
            ch_fnum  <= '0;
            ch_blk   <= '0;
            ch_key   <= '0;
            ch_sus   <= '0;
            ch_inst  <= '0;
            ch_vol   <= '0;
            rhy_en   <= 1'b0;
`ifdef VM2413_RHYTHM_KEY_EN
            rhy_keys <= 5'd0;
`endif
        end else begin
            if (wr_fnum)
                ch_fnum[pend_ch][7:0] <= pend_data;
            if (wr_ctl) begin
                ch_sus[pend_ch]     <= pend_data[5];
                ch_key[pend_ch]     <= pend_data[4];
                ch_blk[pend_ch]     <= pend_data[3:1];
                ch_fnum[pend_ch][8] <= pend_data[0];
            end
            if (wr_ivol) begin
                ch_inst[pend_ch] <= pend_data[7:4];
                ch_vol[pend_ch]  <= pend_data[3:0];
            end
            if (wr_rhy) begin
                rhy_en   <= pend_data[5];
`ifdef VM2413_RHYTHM_KEY_EN
                rhy_keys <= pend_data[4:0];
`endif
            end
        end
    end

    // Voice port: commits to 0x00-0x07 go straight out as a strobe
    always_ff @(posedge clk) begin
        if (reset) begin
            voice_wr   <= 1'b0;
            voice_addr <= 3'd0;
            voice_data <= 8'd0;
        end else begin
            voice_wr <= wr_voice;
            if (wr_voice) begin
                voice_addr <= pend_addr[2:0];
                voice_data <= pend_data;
            end
        end
    end

    // Read side. Two slots share a channel (modulator/carrier).
    always_comb begin
        load    = clkena && (stage == 2'd0);
        slot_ok = (slot < 5'd18);
        rd_ch   = slot[4:1];
    end

`ifdef VM2413_RHYTHM_KEY_EN
    logic rhy_key_bit;

    // Percussion slots: BD spans both slots of channel 6, the remaining four
    // instruments take one slot each in channels 7 and 8.
    always_comb begin
        rhy_key_bit = 1'b0;
        case (slot)
            5'd12, 5'd13: rhy_key_bit = rhy_keys[4];   // BD
            5'd14:        rhy_key_bit = rhy_keys[0];   // HH
            5'd15:        rhy_key_bit = rhy_keys[3];   // SD
            5'd16:        rhy_key_bit = rhy_keys[2];   // TOM
            5'd17:        rhy_key_bit = rhy_keys[1];   // CYM
            default:      rhy_key_bit = 1'b0;
        endcase
        key_next = ch_key[rd_ch] | (rhy_en & rhy_key_bit);
    end
`else
    // The 0x0E key bits have no effect in this build, so they are not kept.
    always_comb begin
        key_next = ch_key[rd_ch];
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            fnum <= 9'd0;
            blk  <= 3'd0;
            key  <= 1'b0;
            sus  <= 1'b0;
            inst <= 4'd0;
            vol  <= 4'd0;
        end else if (load) begin
            if (slot_ok) begin
                fnum <= ch_fnum[rd_ch];
                blk  <= ch_blk[rd_ch];
                key  <= key_next;
                sus  <= ch_sus[rd_ch];
                inst <= ch_inst[rd_ch];
                vol  <= ch_vol[rd_ch];
            end else begin
                fnum <= 9'd0;
                blk  <= 3'd0;
                key  <= 1'b0;
                sus  <= 1'b0;
                inst <= 4'd0;
                vol  <= 4'd0;
            end
        end
    end

    assign rhythm = rhy_en;

endmodule
